// File: rtl/univ_reg_pkg.sv
// Shared types for the universal shift register: operation modes and serializer states.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    SHL   = 3'd2,
    SHR   = 3'd3,
    ROL   = 3'd4,
    ROR   = 3'd5,
    CLEAR = 3'd6,
    SET   = 3'd7
  } mode_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg; slave is the register side, master the user side.
interface univ_shift_reg_if
  import univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             sout;
  logic             busy;
  logic             done;

  modport slave (
    input  en, mode, d, sin_l, sin_r, start,
    output q, q_n, sout, busy, done
  );

  modport master (
    output en, mode, d, sin_l, sin_r, start,
    input  q, q_n, sout, busy, done
  );
endinterface

// File: rtl/ser_bit_counter.sv
// Serializer bit counter: clears on transfer start, counts shifted bits, flags the last one.
module ser_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0] cnt_q;

  assign tc_o = (cnt_q == CntW'(WIDTH - 1));

  // Counter parks at terminal count; the next start clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !tc_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with load/shift/rotate modes and an MSB-first serializer.
module univ_shift_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  univ_shift_reg_if.slave        bus_io
);
  if (WIDTH < 2) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_q = RESET_VALUE;
  state_t           state_q = IDLE;
  logic             done_q = 1'b0;
  logic             start_ok;
  logic             tc;

  assign start_ok = (state_q == IDLE) && bus_io.start;

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (start_ok),
    .inc_i (state_q == SHIFT),
    .tc_o  (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RESET_VALUE;
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_io.start) begin
            q_q     <= bus_io.d;
            state_q <= SHIFT;
          end else if (bus_io.en) begin
            unique case (bus_io.mode)
              HOLD:  q_q <= q_q;
              LOAD:  q_q <= bus_io.d;
              SHL:   q_q <= {q_q[WIDTH-2:0], bus_io.sin_r};
              SHR:   q_q <= {bus_io.sin_l, q_q[WIDTH-1:1]};
              ROL:   q_q <= {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              ROR:   q_q <= {q_q[0], q_q[WIDTH-1:1]};
              CLEAR: q_q <= '0;
              SET:   q_q <= '1;
              default: q_q <= q_q;
            endcase
          end
        end
        SHIFT: begin
          q_q <= {q_q[WIDTH-2:0], 1'b0};
          if (tc) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.q    = q_q;
  assign bus_io.q_n  = ~q_q;
  assign bus_io.sout = q_q[WIDTH-1];
  assign bus_io.busy = (state_q == SHIFT);
  assign bus_io.done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: mode vector table plus serializer sequences (WIDTH 8 and 2).
module tb_univ_shift_reg;
  import univ_reg_pkg::*;

  logic clk = 1'b0;
  logic reset8;
  logic reset2;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8)) bus8 ();
  univ_shift_reg_if #(.WIDTH(2)) bus2 ();

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk    (clk),
    .reset  (reset8),
    .bus_io (bus8.slave)
  );

  univ_shift_reg #(.WIDTH(2), .RESET_VALUE(2'b00)) dut2 (
    .clk    (clk),
    .reset  (reset2),
    .bus_io (bus2.slave)
  );

  typedef struct {
    logic       rst;
    logic       en;
    mode_t      mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle8();
    reset8     = 1'b0;
    bus8.start = 1'b0;
    bus8.en    = 1'b0;
    bus8.mode  = HOLD;
    bus8.d     = 8'h00;
    bus8.sin_l = 1'b0;
    bus8.sin_r = 1'b0;
  endtask

  // Starts a transfer of dv and checks every busy cycle; returns on the done cycle.
  task automatic xfer8(input logic [7:0] dv, input bit junk, input string tag);
    bus8.start = 1'b1;
    bus8.d     = dv;
    tick();
    idle8();
    for (int i = 0; i < 8; i++) begin
      if (junk) begin
        bus8.start = 1'b1;
        bus8.en    = 1'b1;
        bus8.mode  = LOAD;
        bus8.d     = 8'hFF;
      end
      chk($sformatf("%s_bit%0d {busy,sout}", tag, i), {30'd0, bus8.busy, bus8.sout},
          {30'd0, 1'b1, dv[7-i]});
      tick();
    end
    idle8();
    chk($sformatf("%s_end {busy,done,q}", tag), {22'd0, bus8.busy, bus8.done, bus8.q},
        {22'd0, 1'b0, 1'b1, 8'h00});
  endtask

  vec_t vecs[16];
  bit   saw_done;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, HOLD,  8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 1'b1, LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[2]  = '{1'b0, 1'b1, SHL,   8'h00, 1'b0, 1'b1, 8'h2D};
    vecs[3]  = '{1'b0, 1'b1, LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[4]  = '{1'b0, 1'b1, SHR,   8'h00, 1'b1, 1'b0, 8'hCB};
    vecs[5]  = '{1'b0, 1'b1, LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[6]  = '{1'b0, 1'b1, ROL,   8'h00, 1'b0, 1'b0, 8'h2D};
    vecs[7]  = '{1'b0, 1'b1, LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[8]  = '{1'b0, 1'b1, ROR,   8'h00, 1'b0, 1'b0, 8'h4B};
    vecs[9]  = '{1'b0, 1'b1, CLEAR, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b1, SET,   8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[11] = '{1'b0, 1'b0, CLEAR, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[12] = '{1'b0, 1'b0, LOAD,  8'h3C, 1'b0, 1'b0, 8'hFF};
    vecs[13] = '{1'b0, 1'b1, HOLD,  8'h3C, 1'b1, 1'b1, 8'hFF};
    vecs[14] = '{1'b0, 1'b1, SHL,   8'h00, 1'b0, 1'b0, 8'hFE};
    vecs[15] = '{1'b0, 1'b1, SHR,   8'h00, 1'b0, 1'b0, 8'h7F};

    idle8();
    reset2     = 1'b1;
    bus2.start = 1'b0;
    bus2.en    = 1'b0;
    bus2.mode  = HOLD;
    bus2.d     = 2'b00;
    bus2.sin_l = 1'b0;
    bus2.sin_r = 1'b0;
    #1;

    for (int i = 0; i < 16; i++) begin
      reset8     = vecs[i].rst;
      bus8.en    = vecs[i].en;
      bus8.mode  = vecs[i].mode;
      bus8.d     = vecs[i].d;
      bus8.sin_l = vecs[i].sl;
      bus8.sin_r = vecs[i].sr;
      tick();
      chk($sformatf("vec%0d {q,q_n,busy,done,sout}", i),
          {13'd0, bus8.q, bus8.q_n, bus8.busy, bus8.done, bus8.sout},
          {13'd0, vecs[i].exp, ~vecs[i].exp, 1'b0, 1'b0, vecs[i].exp[7]});
    end
    idle8();
    reset2 = 1'b0;

    xfer8(8'hC3, 1'b0, "ser_c3");
    tick();
    chk("after_done done", {31'd0, bus8.done}, 32'd0);

    xfer8(8'hA6, 1'b1, "ser_junk");
    tick();

    xfer8(8'h81, 1'b0, "b2b_first");
    xfer8(8'h7E, 1'b0, "b2b_second");
    tick();

    // Reset during busy cycle 3 aborts without a done pulse.
    bus8.start = 1'b1;
    bus8.d     = 8'hC3;
    tick();
    idle8();
    for (int i = 0; i < 3; i++) tick();
    chk("pre_abort busy", {31'd0, bus8.busy}, 32'd1);
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    chk("abort {q,busy,done}", {22'd0, bus8.q, bus8.busy, bus8.done},
        {22'd0, 8'hA5, 1'b0, 1'b0});
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("abort no_done", {31'd0, saw_done}, 32'd0);

    reset8     = 1'b1;
    bus8.start = 1'b1;
    bus8.d     = 8'h55;
    tick();
    idle8();
    chk("rst_vs_start {q,busy}", {23'd0, bus8.q, bus8.busy}, {23'd0, 8'hA5, 1'b0});

    bus8.start = 1'b1;
    bus8.en    = 1'b1;
    bus8.mode  = SET;
    bus8.d     = 8'h3C;
    tick();
    idle8();
    chk("start_vs_set {q,busy}", {23'd0, bus8.q, bus8.busy}, {23'd0, 8'h3C, 1'b1});
    for (int i = 0; i < 8; i++) tick();
    chk("start_vs_set end {q,done}", {23'd0, bus8.q, bus8.done}, {23'd0, 8'h00, 1'b1});

    bus2.start = 1'b1;
    bus2.d     = 2'b10;
    tick();
    bus2.start = 1'b0;
    bus2.d     = 2'b00;
    chk("w2_c0 {busy,sout,done}", {29'd0, bus2.busy, bus2.sout, bus2.done}, {29'd0, 3'b110});
    tick();
    chk("w2_c1 {busy,sout,done}", {29'd0, bus2.busy, bus2.sout, bus2.done}, {29'd0, 3'b100});
    tick();
    chk("w2_c2 {busy,done,q}", {28'd0, bus2.busy, bus2.done, bus2.q}, {28'd0, 4'b0100});
    tick();
    chk("w2_c3 done", {31'd0, bus2.done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register: a WIDTH-bit register with synchronous reset, clock enable, a set of parallel-load/shift/rotate modes, and a built-in MSB-first serializer with a start/busy/done handshake. It is the general-purpose storage element for datapaths that need more than a single D flip-flop, such as counters' shadow registers, serial links, and LFSR seeds. It keeps the single-bit block's complementary output, generalised to a word.

## Interface
- WIDTH, 8, register width in bits; must be at least 2 (elaboration error otherwise)
- RESET_VALUE, 0 (WIDTH bits), value loaded into q by reset and at power-up (initial value)
- clk  in  1  clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high; highest priority
- en  in  1  clock enable for mode operations; ignored while busy
- mode  in  3  operation select, see Operation
- d  in  WIDTH  parallel load data (LOAD mode and serializer start)
- sin_l  in  1  serial bit entering at the MSB on SHR
- sin_r  in  1  serial bit entering at the LSB on SHL
- start  in  1  begin serializing d; honoured only in IDLE
- q  out  WIDTH  register contents
- q_n  out  WIDTH  combinational ~q
- sout  out  1  combinational q[WIDTH-1]
- busy  out  1  high while serializing
- done  out  1  one-cycle pulse after the last serial bit

## Operation
- The design has two states, IDLE and SHIFT. There is a bit counter cnt of width $clog2(WIDTH).
- Reset in any state sets q=RESET_VALUE, state=IDLE, cnt=0, busy=0, done=0. A reset mid-serialization aborts the transfer and no done pulse is produced.
- IDLE, start=1: q<=d, cnt<=0, state<=SHIFT. start takes priority over en and mode.
- IDLE, start=0, en=0: q holds.
- IDLE, start=0, en=1, the mode encodings are:
  - 0 HOLD: q holds.
  - 1 LOAD: q<=d.
  - 2 SHL: q<={q[W-2:0],sin_r}.
  - 3 SHR: q<={sin_l,q[W-1:1]}.
  - 4 ROL: q<={q[W-2:0],q[W-1]}.
  - 5 ROR: q<={q[0],q[W-1:1]}.
  - 6 CLEAR: q<=0.
  - 7 SET: q<=all ones.
- SHIFT, every edge: q<={q[W-2:0],1'b0}.
  - If cnt==WIDTH-1, then state<=IDLE and done<=1.
  - Otherwise cnt<=cnt+1.
  - en, mode and start are ignored in SHIFT.
- done is registered. It is cleared on every edge where it is not being set.
- busy = (state==SHIFT), decoded from state.

## Timing
- All q updates take effect 1 cycle after the sampling edge. There is no combinational path from inputs to q, busy or done.
- Serializer: start is sampled at edge k.
  - Edges k+1 .. k+WIDTH-1 each shift one bit.
  - Edge k+WIDTH: final shift, state returns to IDLE.
  - busy is high for exactly WIDTH cycles, from edge k up to edge k+WIDTH.
  - sout presents d[WIDTH-1-i] during busy cycle i (i = 0..WIDTH-1).
  - done is high for exactly the one cycle after edge k+WIDTH. After that transfer q is 0.
- Back-to-back: start may be asserted in the same cycle that done is high, since the state is IDLE. The next transfer begins with no gap cycle, so busy is low for one cycle between transfers.
- start held high continuously starts a new transfer on every IDLE cycle.
- Reset and start asserted together: reset wins, and the block ends in IDLE with q=RESET_VALUE.

## Structure
- A shared package (univ_reg_pkg) holds:
  - the mode_t enum: HOLD, LOAD, SHL, SHR, ROL, ROR, CLEAR, SET;
  - the state_t enum: IDLE, SHIFT.
- One sub-module, ser_bit_counter, is natural. It is a WIDTH-parameterised counter with clr, inc and a terminal-count output, and it drives the SHIFT exit.
- The next-q mux sits in a single clocked process in the top module.

## Test plan
- Reset with RESET_VALUE=8'hA5 and WIDTH=8: after the edge, q=8'hA5, q_n=8'h5A, busy=0, done=0. Reset during SHIFT cycle 3: the next cycle gives q=8'hA5 and busy=0, and done never pulses.
- Modes, starting from q=8'b1001_0110 with en=1:
  - SHL with sin_r=1 gives 8'b0010_1101.
  - SHR with sin_l=1 gives 8'b1100_1011.
  - ROL gives 8'b0010_1101.
  - ROR gives 8'b0100_1011.
  - CLEAR gives 8'h00.
  - SET gives 8'hFF.
  - With en=0 in any mode, q is unchanged.
- Serialize d=8'hC3: sout sequence is 1,1,0,0,0,0,1,1 across the 8 busy cycles. done is high for 1 cycle at cycle 9, and q=0 afterward.
- Ignore inputs while busy: assert start, mode=LOAD, en=1 and d=8'hFF during SHIFT. The bit stream is unaffected and busy length stays 8.
- Back-to-back: pulse start=1 with d=8'h81 and then with d=8'h7E, the second start coinciding with done. The result is 16 correct bits with exactly one non-busy cycle between the two transfers.
- Priority and edge cases:
  - start and mode=SET in the same IDLE cycle: q=d, not all ones.
  - WIDTH=2 instance: busy lasts 2 cycles, and done follows on cycle 3.
